// File: rtl/ufifo_pkg.sv
// Shared constants for the programmable UART FIFO: status word layout, legal depth range
// and error-flag bit positions.
package ufifo_pkg;

  localparam int unsigned LGFLEN_MIN = 2;
  localparam int unsigned LGFLEN_MAX = 9;

  localparam int unsigned ERR_OVFL = 1;
  localparam int unsigned ERR_UNFL = 0;

  localparam int unsigned STATUS_W         = 16;
  localparam int unsigned STATUS_LG_LSB    = 12;
  localparam int unsigned STATUS_LG_W      = 4;
  localparam int unsigned STATUS_FILL_LSB  = 2;
  localparam int unsigned STATUS_FILL_W    = 10;
  localparam int unsigned STATUS_AFULL_BIT = 1;
  localparam int unsigned STATUS_NEMPTY_BIT = 0;

  function automatic logic [STATUS_W-1:0] pack_status(
    input logic [STATUS_LG_W-1:0]   lg,
    input logic [STATUS_FILL_W-1:0] fill,
    input logic                     afull,
    input logic                     empty_n
  );
    logic [STATUS_W-1:0] s;
    s = '0;
    s[STATUS_LG_LSB +: STATUS_LG_W]     = lg;
    s[STATUS_FILL_LSB +: STATUS_FILL_W] = fill;
    s[STATUS_AFULL_BIT]                 = afull;
    s[STATUS_NEMPTY_BIT]                = empty_n;
    return s;
  endfunction

endpackage

// File: rtl/ufifo_prog_if.sv
// Bus bundle between the FIFO and its producer/consumer. The o_peak wire exists only when
// UFIFO_PROG_PEAK_EN is defined.
interface ufifo_prog_if #(
  parameter int unsigned BW     = 8,
  parameter int unsigned LGFLEN = 4
) ();

  logic              i_wr;
  logic [BW-1:0]     i_data;
  logic              i_rd;
  logic [BW-1:0]     o_data;
  logic              o_empty_n;
  logic              o_full;
  logic [LGFLEN:0]   o_fill;
  logic [LGFLEN:0]   i_afull_lvl;
  logic [LGFLEN:0]   i_aempty_lvl;
  logic              o_afull;
  logic              o_aempty;
  logic              i_err_clr;
  logic [1:0]        o_err;
  logic [15:0]       o_status;
`ifdef UFIFO_PROG_PEAK_EN
  logic [LGFLEN:0]   o_peak;
`endif

  modport master (
    output i_wr, i_data, i_rd, i_afull_lvl, i_aempty_lvl, i_err_clr,
`ifdef UFIFO_PROG_PEAK_EN
    input  o_peak,
`endif
    input  o_data, o_empty_n, o_full, o_fill, o_afull, o_aempty, o_err, o_status
  );

  modport slave (
    input  i_wr, i_data, i_rd, i_afull_lvl, i_aempty_lvl, i_err_clr,
`ifdef UFIFO_PROG_PEAK_EN
    output o_peak,
`endif
    output o_data, o_empty_n, o_full, o_fill, o_afull, o_aempty, o_err, o_status
  );

endinterface

// File: rtl/ufifo_prog_mem.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read, contents
// are never reset.
module ufifo_prog_mem #(
  parameter int unsigned BW     = 8,
  parameter int unsigned LGFLEN = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [LGFLEN-1:0] waddr_i,
  input  logic [BW-1:0]     wdata_i,
  input  logic [LGFLEN-1:0] raddr_i,
  output logic [BW-1:0]     rdata_o
);

  localparam int unsigned FLEN = 1 << LGFLEN;

  logic [BW-1:0] mem_q [FLEN];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ufifo_prog.sv
// Programmable first-word-fall-through FIFO with thresholds and sticky error flags.
// Define UFIFO_PROG_PEAK_EN to add the o_peak high-water mark.
module ufifo_prog
  import ufifo_pkg::*;
#(
  parameter int unsigned BW     = 8,
  parameter int unsigned LGFLEN = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  ufifo_prog_if.slave  bus
);

  localparam int unsigned FLEN = 1 << LGFLEN;
  localparam int unsigned FW   = LGFLEN + 1;
  localparam logic [LGFLEN:0] FillFull = FW'(FLEN);

  if (LGFLEN < LGFLEN_MIN || LGFLEN > LGFLEN_MAX) begin : gen_bad_lgflen
    $error("ufifo_prog: LGFLEN out of range");
  end

  logic [LGFLEN-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              full_q, full_d;
  logic              empty_n_q, empty_n_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic [1:0]        err_q, err_d, err_set;
  logic              wr_ok, rd_ok;

  always_comb begin
    // A full FIFO is never empty, so a concurrent read always frees the slot being written.
    rd_ok = bus.i_rd && empty_n_q;
    wr_ok = bus.i_wr && (!full_q || bus.i_rd);

    wptr_d = wr_ok ? wptr_q + LGFLEN'(1) : wptr_q;
    rptr_d = rd_ok ? rptr_q + LGFLEN'(1) : rptr_q;

    unique case ({wr_ok, rd_ok})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    full_d    = (fill_d == FillFull);
    empty_n_d = (fill_d != '0);
    afull_d   = (fill_d >= bus.i_afull_lvl);
    aempty_d  = (fill_d <= bus.i_aempty_lvl);

    err_set           = '0;
    err_set[ERR_OVFL] = bus.i_wr && !wr_ok;
    err_set[ERR_UNFL] = bus.i_rd && !rd_ok;
    err_d = (bus.i_err_clr ? 2'b00 : err_q) | err_set;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      empty_n_q <= 1'b0;
      afull_q   <= (bus.i_afull_lvl == '0);
      aempty_q  <= 1'b1;
      err_q     <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fill_q    <= fill_d;
      full_q    <= full_d;
      empty_n_q <= empty_n_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      err_q     <= err_d;
    end
  end

  ufifo_prog_mem #(
    .BW     (BW),
    .LGFLEN (LGFLEN)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (wr_ok),
    .waddr_i (wptr_q),
    .wdata_i (bus.i_data),
    .raddr_i (rptr_q),
    .rdata_o (bus.o_data)
  );

`ifdef UFIFO_PROG_PEAK_EN
  logic [LGFLEN:0] peak_q, peak_d;

  always_comb begin
    if (bus.i_err_clr) begin
      peak_d = fill_d;
    end else begin
      peak_d = (fill_d > peak_q) ? fill_d : peak_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign bus.o_peak = peak_q;
`endif

  assign bus.o_empty_n = empty_n_q;
  assign bus.o_full    = full_q;
  assign bus.o_fill    = fill_q;
  assign bus.o_afull   = afull_q;
  assign bus.o_aempty  = aempty_q;
  assign bus.o_err     = err_q;
  assign bus.o_status  = pack_status(STATUS_LG_W'(LGFLEN), STATUS_FILL_W'(fill_q), afull_q,
                                     empty_n_q);

endmodule

// File: tb/tb_ufifo_prog.sv
// Self-checking bench for ufifo_prog: directed steps plus random traffic against a queue model.
module tb_ufifo_prog;

  localparam int unsigned BW   = 8;
  localparam int unsigned LG   = 4;
  localparam int unsigned FLEN = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ufifo_prog_if #(.BW(BW), .LGFLEN(LG)) bus ();

  ufifo_prog #(.BW(BW), .LGFLEN(LG)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [BW-1:0] q[$];
  logic [1:0]    m_err;
  int            m_peak;
  int            afl, ael;
  int            n_vec = 0;
  int            n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int f;
    f = q.size();
    chk("fill", 64'(bus.o_fill), 64'(f));
    chk("full", 64'(bus.o_full), 64'(f == FLEN));
    chk("empty_n", 64'(bus.o_empty_n), 64'(f > 0));
    chk("afull", 64'(bus.o_afull), 64'(f >= afl));
    chk("aempty", 64'(bus.o_aempty), 64'(f <= ael));
    chk("err", 64'(bus.o_err), 64'(m_err));
    chk("status", 64'(bus.o_status), 64'((LG << 12) | (f << 2) | ((f >= afl) << 1) | (f > 0)));
    if (f > 0) chk("data", 64'(bus.o_data), 64'(q[0]));
`ifdef UFIFO_PROG_PEAK_EN
    chk("peak", 64'(bus.o_peak), 64'(m_peak));
`endif
  endtask

  task automatic set_lvls(input int a, input int e);
    afl = a;
    ael = e;
    bus.i_afull_lvl  = 5'(a);
    bus.i_aempty_lvl = 5'(e);
  endtask

  task automatic step(input bit wr, input logic [BW-1:0] d, input bit rd, input bit clr);
    bit wa, ra;
    bus.i_wr      = wr;
    bus.i_data    = d;
    bus.i_rd      = rd;
    bus.i_err_clr = clr;
    wa = wr && (q.size() < FLEN || rd);
    ra = rd && (q.size() > 0);
    @(posedge clk);
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(d);
    if (clr) m_err = 2'b00;
    if (wr && !wa) m_err[1] = 1'b1;
    if (rd && !ra) m_err[0] = 1'b1;
    if (clr) m_peak = q.size();
    else if (q.size() > m_peak) m_peak = q.size();
    #1;
    bus.i_wr      = 1'b0;
    bus.i_rd      = 1'b0;
    bus.i_err_clr = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    m_err  = 2'b00;
    m_peak = 0;
    #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    logic [BW-1:0] d;
    rst = 1'b0;
    bus.i_wr = 1'b0; bus.i_rd = 1'b0; bus.i_err_clr = 1'b0; bus.i_data = '0;
    set_lvls(0, 0);
    #2;

    // reset, with afull threshold 0 the flag must come up at reset
    do_reset();
    chk("rst_afull_lvl0", 64'(bus.o_afull), 64'(1));
    set_lvls(12, 3);
    do_reset();

    // single word falls through after one edge
    step(1, 8'hA5, 0, 0);
    chk("fwft_a5", 64'(bus.o_data), 64'hA5);
    step(0, 8'h00, 1, 0);
    chk("fwft_empty", 64'(bus.o_empty_n), 64'(0));

    // fill to 16, then overflow
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0);
    chk("full16", 64'(bus.o_full), 64'(1));
    step(1, 8'hEE, 0, 0);
    chk("ovfl_err", 64'(bus.o_err), 64'(2'b10));
    chk("ovfl_head", 64'(bus.o_data), 64'h10);
    step(0, 8'h00, 0, 1);

    // stream across pointer wrap while full
    for (int i = 0; i < 100; i++) step(1, 8'($urandom), 1, 0);
    chk("stream_fill", 64'(bus.o_fill), 64'(16));

    // drain, crossing the 12 and 3 thresholds
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("unfl_err", 64'(bus.o_err), 64'(2'b01));
    step(0, 8'h00, 0, 1);
    chk("clr_err", 64'(bus.o_err), 64'(0));
    step(0, 8'h00, 1, 1);
    chk("clr_vs_set", 64'(bus.o_err), 64'(2'b01));
    step(1, 8'h3C, 1, 1);
    chk("rd_empty_no_wt", 64'(bus.o_fill), 64'(1));

    // threshold edges
    do_reset();
    for (int i = 0; i < 12; i++) step(1, 8'(i), 0, 0);
    chk("afull_at12", 64'(bus.o_afull), 64'(1));
    for (int i = 0; i < 9; i++) step(0, 8'h00, 1, 0);
    chk("aempty_at3", 64'(bus.o_aempty), 64'(1));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) set_lvls(int'($urandom_range(0, 17)), int'($urandom_range(0, 17)));
      if ($urandom_range(0, 199) == 0) do_reset();
      d = 8'($urandom);
      step($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 40), d,
           $urandom_range(0, 99) < 50, $urandom_range(0, 19) == 0);
    end

`ifdef UFIFO_PROG_PEAK_EN
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 8'(i), 0, 0);
    for (int i = 0; i < 9; i++) step(0, 8'h00, 1, 0);
    chk("peak9", 64'(bus.o_peak), 64'(9));
    step(0, 8'h00, 0, 1);
    chk("peak_clr", 64'(bus.o_peak), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
